// File: rtl/trace_pkg.sv
// Shared types and constants for the pipeline execution monitor and its trace FIFO.
package trace_pkg;

  localparam int unsigned TR_XLEN = 64;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned TR_W    = PC_W + RD_W + TR_XLEN;

  // Event channel indices into the ev strobe vector
  localparam int unsigned EV_STALL    = 0;
  localparam int unsigned EV_FLUSH    = 1;
  localparam int unsigned EV_LOAD_USE = 2;
  localparam int unsigned EV_BR_TAKEN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [RD_W-1:0]    rd;
    logic [TR_XLEN-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through retirement trace FIFO with drop-newest or evict-oldest on overflow.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = TR_W,
  parameter int unsigned OVERWRITE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop, do_write, evict, rd_adv;

  // Extra pointer MSB distinguishes full from empty when the indices match
  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    do_write = push & (~full | do_pop | (OVERWRITE != 0));
    evict    = push & full & ~do_pop & (OVERWRITE != 0);
    drop     = push & full & ~do_pop;
    rd_adv   = do_pop | evict;
    wptr_d   = wptr_q + (AW+1)'(do_write);
    rptr_d   = rptr_q + (AW+1)'(rd_adv);
    count_d  = count_q;
    if (do_write && !rd_adv) begin
      count_d = count_q + (AW+1)'(1);
    end else if (rd_adv && !do_write) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; pointers define which entries are meaningful
  always_ff @(posedge clk) begin
    if (do_write && !clr) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign count = count_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Execution monitor beside the pipelined core: run-control FSM with drain window,
// saturating cycle/retire/event counters and a retirement trace FIFO.
module pipe_trace_monitor
  import trace_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned N_EV      = 4,
  parameter int unsigned DRAIN_CYC = 5,
  parameter int unsigned OVERWRITE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  input  logic                      end_program,
  input  logic                      wb_valid,
  input  logic                      wb_we,
  input  logic [PC_W-1:0]           wb_pc,
  input  logic [RD_W-1:0]           wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic [N_EV-1:0]           ev,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          cycles,
  output logic [CNT_W-1:0]          retired,
  output logic [N_EV*CNT_W-1:0]     ev_cnt,
  output logic [CNT_W-1:0]          dropped,
  input  logic                      tr_rd,
  output logic                      tr_valid,
  output logic [PC_W+RD_W+XLEN-1:0] tr_data,
  output logic [$clog2(DEPTH):0]    tr_count
);

  localparam int unsigned ENT_W = PC_W + RD_W + XLEN;
  localparam int unsigned DRN_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  run_state_e                    state_q, state_d;
  logic [DRN_W-1:0]              drain_q, drain_d;
  logic                          busy_q, done_q;
  logic [CNT_W-1:0]              cycles_q, retired_q, dropped_q;
  logic [N_EV-1:0][CNT_W-1:0]    ev_q;
  logic                          active, push;
  logic                          fifo_full, fifo_empty, fifo_drop;

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign push   = active & ~clear & wb_valid & wb_we & (wb_rd != '0);

  // Run control: clear overrides every transition
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (clear) begin
      state_d = ST_IDLE;
      drain_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (end_program) begin
            state_d = ST_DRAIN;
            drain_d = DRN_W'(DRAIN_CYC - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_d = ST_DONE;
          else               drain_d = drain_q - DRN_W'(1);
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Saturating counters, live only in RUN/DRAIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles_q  <= '0;
      retired_q <= '0;
      dropped_q <= '0;
      ev_q      <= '0;
    end else if (clear) begin
      cycles_q  <= '0;
      retired_q <= '0;
      dropped_q <= '0;
      ev_q      <= '0;
    end else if (active) begin
      if (cycles_q != '1)              cycles_q  <= cycles_q + CNT_W'(1);
      if (wb_valid && retired_q != '1) retired_q <= retired_q + CNT_W'(1);
      if (fifo_drop && dropped_q != '1) dropped_q <= dropped_q + CNT_W'(1);
      for (int k = 0; k < N_EV; k++) begin
        if (ev[k] && ev_q[k] != '1) ev_q[k] <= ev_q[k] + CNT_W'(1);
      end
    end
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (ENT_W),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .push  (push),
    .wdata ({wb_pc, wb_rd, wb_data}),
    .pop   (tr_rd),
    .rdata (tr_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (tr_count),
    .drop  (fifo_drop)
  );

  // A drop can only arise from a push into a full FIFO
  a_drop_full : assert property (@(posedge clk) disable iff (!reset) fifo_drop |-> fifo_full);

  assign busy     = busy_q;
  assign done     = done_q;
  assign cycles   = cycles_q;
  assign retired  = retired_q;
  assign dropped  = dropped_q;
  assign ev_cnt   = ev_q;
  assign tr_valid = ~fifo_empty;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor: default, OVERWRITE=1 and CNT_W=4 instances share stimulus.
module tb_pipe_trace_monitor;
  import trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, clear, end_program, wb_valid, wb_we, tr_rd;
  logic [31:0] wb_pc;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [3:0]  ev;

  logic         busy_m, done_m, tr_valid_m;
  logic [31:0]  cycles_m, retired_m, dropped_m;
  logic [127:0] ev_cnt_m;
  logic [100:0] tr_data_m;
  logic [4:0]   tr_count_m;

  logic         busy_o, done_o, tr_valid_o;
  logic [31:0]  cycles_o, retired_o, dropped_o;
  logic [127:0] ev_cnt_o;
  logic [100:0] tr_data_o;
  logic [4:0]   tr_count_o;

  logic         busy_s, done_s, tr_valid_s;
  logic [3:0]   cycles_s, retired_s, dropped_s;
  logic [15:0]  ev_cnt_s;
  logic [100:0] tr_data_s;
  logic [4:0]   tr_count_s;

  int vectors = 0;
  int miscompares = 0;
  trace_entry_t e_m, e_o;

  always #5 clk = ~clk;

  pipe_trace_monitor u_main (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .ev(ev),
    .busy(busy_m), .done(done_m), .cycles(cycles_m), .retired(retired_m), .ev_cnt(ev_cnt_m),
    .dropped(dropped_m), .tr_rd(tr_rd), .tr_valid(tr_valid_m), .tr_data(tr_data_m), .tr_count(tr_count_m));

  pipe_trace_monitor #(.OVERWRITE(1)) u_ow (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .ev(ev),
    .busy(busy_o), .done(done_o), .cycles(cycles_o), .retired(retired_o), .ev_cnt(ev_cnt_o),
    .dropped(dropped_o), .tr_rd(tr_rd), .tr_valid(tr_valid_o), .tr_data(tr_data_o), .tr_count(tr_count_o));

  pipe_trace_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .end_program(end_program),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .ev(ev),
    .busy(busy_s), .done(done_s), .cycles(cycles_s), .retired(retired_s), .ev_cnt(ev_cnt_s),
    .dropped(dropped_s), .tr_rd(tr_rd), .tr_valid(tr_valid_s), .tr_data(tr_data_s), .tr_count(tr_count_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; clear = 1'b0; end_program = 1'b0; wb_valid = 1'b0; wb_we = 1'b0;
    tr_rd = 1'b0; wb_pc = '0; wb_rd = '0; wb_data = '0; ev = '0;
  endtask

  task automatic restart();
    idle_inputs();
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic push_entry(input logic [31:0] pc, input logic [4:0] rd, input logic [63:0] data);
    wb_valid = 1'b1; wb_we = 1'b1; wb_pc = pc; wb_rd = rd; wb_data = data;
    tick();
    wb_valid = 1'b0; wb_we = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy_m); end
    vectors++; if (done_m !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done_m); end
    vectors++; if (cycles_m !== 32'd0) begin miscompares++; $display("FAIL reset_cycles got %0d want 0", cycles_m); end
    vectors++; if (retired_m !== 32'd0) begin miscompares++; $display("FAIL reset_retired got %0d want 0", retired_m); end
    vectors++; if (tr_valid_m !== 1'b0) begin miscompares++; $display("FAIL reset_tr_valid got %0b want 0", tr_valid_m); end
    vectors++; if (tr_count_m !== 5'd0) begin miscompares++; $display("FAIL reset_tr_count got %0d want 0", tr_count_m); end
    vectors++; if (dropped_m !== 32'd0) begin miscompares++; $display("FAIL reset_dropped got %0d want 0", dropped_m); end
  endtask

  task automatic test_run_drain();
    restart();
    vectors++; if (busy_m !== 1'b1) begin miscompares++; $display("FAIL run_busy_after_start got %0b want 1", busy_m); end
    vectors++; if (cycles_m !== 32'd0) begin miscompares++; $display("FAIL run_cycles_at_start got %0d want 0", cycles_m); end
    for (int i = 0; i < 16; i++) begin
      wb_valid = 1'b1;
      ev[0] = (i % 2 == 0);
      end_program = (i == 10);
      tick();
      if (i == 14) begin
        vectors++; if (done_m !== 1'b0) begin miscompares++; $display("FAIL drain_early_done got %0b want 0", done_m); end
        vectors++; if (busy_m !== 1'b1) begin miscompares++; $display("FAIL drain_busy got %0b want 1", busy_m); end
      end
    end
    vectors++; if (done_m !== 1'b1) begin miscompares++; $display("FAIL drain_done got %0b want 1", done_m); end
    vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL done_busy got %0b want 0", busy_m); end
    idle_inputs();
    wb_valid = 1'b1; ev = 4'b0011;
    tick();
    idle_inputs();
    vectors++; if (cycles_m !== 32'd16) begin miscompares++; $display("FAIL run_cycles got %0d want 16", cycles_m); end
    vectors++; if (retired_m !== 32'd16) begin miscompares++; $display("FAIL run_retired got %0d want 16", retired_m); end
    vectors++; if (ev_cnt_m[31:0] !== 32'd8) begin miscompares++; $display("FAIL run_ev0 got %0d want 8", ev_cnt_m[31:0]); end
    vectors++; if (ev_cnt_m[63:32] !== 32'd0) begin miscompares++; $display("FAIL run_ev1 got %0d want 0", ev_cnt_m[63:32]); end
    vectors++; if (done_m !== 1'b1) begin miscompares++; $display("FAIL done_hold got %0b want 1", done_m); end
  endtask

  task automatic test_fifo_overflow();
    restart();
    for (int i = 0; i < 17; i++) push_entry(32'(i * 4), 5'((i % 31) + 1), 64'hA5A5_0000_0000_0000 | 64'(i));
    vectors++; if (tr_count_m !== 5'd16) begin miscompares++; $display("FAIL drop_count got %0d want 16", tr_count_m); end
    vectors++; if (dropped_m !== 32'd1) begin miscompares++; $display("FAIL drop_dropped got %0d want 1", dropped_m); end
    vectors++; if (tr_count_o !== 5'd16) begin miscompares++; $display("FAIL ow_count got %0d want 16", tr_count_o); end
    vectors++; if (dropped_o !== 32'd1) begin miscompares++; $display("FAIL ow_dropped got %0d want 1", dropped_o); end
    for (int i = 0; i < 16; i++) begin
      e_m = trace_entry_t'(tr_data_m);
      e_o = trace_entry_t'(tr_data_o);
      vectors++; if (e_m.pc !== 32'(i * 4)) begin miscompares++; $display("FAIL drop_pop%0d_pc got %h want %h", i, e_m.pc, 32'(i * 4)); end
      vectors++; if (e_m.data !== (64'hA5A5_0000_0000_0000 | 64'(i))) begin miscompares++; $display("FAIL drop_pop%0d_data got %h", i, e_m.data); end
      vectors++; if (e_o.pc !== 32'((i + 1) * 4)) begin miscompares++; $display("FAIL ow_pop%0d_pc got %h want %h", i, e_o.pc, 32'((i + 1) * 4)); end
      vectors++; if (e_o.rd !== 5'(((i + 1) % 31) + 1)) begin miscompares++; $display("FAIL ow_pop%0d_rd got %0d", i, e_o.rd); end
      tr_rd = 1'b1; tick(); tr_rd = 1'b0;
    end
    vectors++; if (tr_valid_m !== 1'b0) begin miscompares++; $display("FAIL drop_empty got %0b want 0", tr_valid_m); end
    vectors++; if (tr_valid_o !== 1'b0) begin miscompares++; $display("FAIL ow_empty got %0b want 0", tr_valid_o); end
    tr_rd = 1'b1; tick(); tr_rd = 1'b0;
    vectors++; if (tr_count_m !== 5'd0) begin miscompares++; $display("FAIL pop_on_empty got %0d want 0", tr_count_m); end
  endtask

  task automatic test_back_to_back();
    restart();
    for (int i = 0; i < 16; i++) push_entry(32'h100 + 32'(i * 4), 5'd7, 64'(i));
    vectors++; if (tr_count_m !== 5'd16) begin miscompares++; $display("FAIL b2b_fill got %0d want 16", tr_count_m); end
    tr_rd = 1'b1;
    push_entry(32'h200, 5'd9, 64'hDEAD);
    tr_rd = 1'b0;
    e_m = trace_entry_t'(tr_data_m);
    e_o = trace_entry_t'(tr_data_o);
    vectors++; if (tr_count_m !== 5'd16) begin miscompares++; $display("FAIL b2b_count got %0d want 16", tr_count_m); end
    vectors++; if (dropped_m !== 32'd0) begin miscompares++; $display("FAIL b2b_dropped got %0d want 0", dropped_m); end
    vectors++; if (dropped_o !== 32'd0) begin miscompares++; $display("FAIL b2b_ow_dropped got %0d want 0", dropped_o); end
    vectors++; if (e_m.pc !== 32'h104) begin miscompares++; $display("FAIL b2b_head got %h want 104", e_m.pc); end
    vectors++; if (e_o.pc !== 32'h104) begin miscompares++; $display("FAIL b2b_ow_head got %h want 104", e_o.pc); end
    tr_rd = 1'b1;
    repeat (15) tick();
    tr_rd = 1'b0;
    e_m = trace_entry_t'(tr_data_m);
    vectors++; if (e_m.pc !== 32'h200) begin miscompares++; $display("FAIL b2b_tail got %h want 200", e_m.pc); end
    vectors++; if (tr_count_m !== 5'd1) begin miscompares++; $display("FAIL b2b_last_count got %0d want 1", tr_count_m); end
  endtask

  task automatic test_rd_zero_start();
    restart();
    push_entry(32'h300, 5'd0, 64'h1);
    vectors++; if (tr_count_m !== 5'd0) begin miscompares++; $display("FAIL rd0_count got %0d want 0", tr_count_m); end
    vectors++; if (tr_valid_m !== 1'b0) begin miscompares++; $display("FAIL rd0_valid got %0b want 0", tr_valid_m); end
    vectors++; if (retired_m !== 32'd1) begin miscompares++; $display("FAIL rd0_retired got %0d want 1", retired_m); end
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (busy_m !== 1'b1) begin miscompares++; $display("FAIL restart_busy got %0b want 1", busy_m); end
    vectors++; if (cycles_m !== 32'd2) begin miscompares++; $display("FAIL restart_cycles got %0d want 2", cycles_m); end
    clear = 1'b1; tick(); clear = 1'b0;
    end_program = 1'b1; tick(); end_program = 1'b0;
    vectors++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin miscompares++; $display("FAIL idle_end_program got busy %0b done %0b want 0 0", busy_m, done_m); end
  endtask

  task automatic test_saturation();
    restart();
    repeat (20) tick();
    vectors++; if (cycles_s !== 4'hF) begin miscompares++; $display("FAIL sat_cycles got %0d want 15", cycles_s); end
    vectors++; if (cycles_m !== 32'd20) begin miscompares++; $display("FAIL nosat_cycles got %0d want 20", cycles_m); end
  endtask

  task automatic test_clear_drain();
    restart();
    tick();
    end_program = 1'b1; tick(); end_program = 1'b0;
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_pc = 32'h400;
    tick(); tick();
    vectors++; if (tr_count_m !== 5'd2) begin miscompares++; $display("FAIL drain_push got %0d want 2", tr_count_m); end
    clear = 1'b1; tick(); clear = 1'b0;
    vectors++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin miscompares++; $display("FAIL clear_state got busy %0b done %0b want 0 0", busy_m, done_m); end
    vectors++; if (cycles_m !== 32'd0) begin miscompares++; $display("FAIL clear_cycles got %0d want 0", cycles_m); end
    vectors++; if (retired_m !== 32'd0) begin miscompares++; $display("FAIL clear_retired got %0d want 0", retired_m); end
    vectors++; if (tr_count_m !== 5'd0 || tr_valid_m !== 1'b0) begin miscompares++; $display("FAIL clear_fifo got count %0d valid %0b want 0 0", tr_count_m, tr_valid_m); end
    tick();
    vectors++; if (tr_count_m !== 5'd0 || cycles_m !== 32'd0) begin miscompares++; $display("FAIL idle_no_push got count %0d cycles %0d want 0 0", tr_count_m, cycles_m); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    restart();
    ev = 4'b1000;
    for (int i = 0; i < 3; i++) push_entry(32'h500 + 32'(i * 4), 5'd4, 64'(i));
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (busy_m !== 1'b0) begin miscompares++; $display("FAIL areset_busy got %0b want 0", busy_m); end
    vectors++; if (cycles_m !== 32'd0) begin miscompares++; $display("FAIL areset_cycles got %0d want 0", cycles_m); end
    vectors++; if (retired_m !== 32'd0) begin miscompares++; $display("FAIL areset_retired got %0d want 0", retired_m); end
    vectors++; if (ev_cnt_m !== 128'd0) begin miscompares++; $display("FAIL areset_ev got %h want 0", ev_cnt_m); end
    vectors++; if (tr_count_m !== 5'd0 || tr_valid_m !== 1'b0) begin miscompares++; $display("FAIL areset_fifo got count %0d valid %0b want 0 0", tr_count_m, tr_valid_m); end
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    vectors++; if (busy_m !== 1'b0 || cycles_m !== 32'd0) begin miscompares++; $display("FAIL post_reset got busy %0b cycles %0d want 0 0", busy_m, cycles_m); end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_run_drain();
    test_fifo_overflow();
    test_back_to_back();
    test_rd_zero_start();
    test_saturation();
    test_clear_drain();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
